// File: rtl/xnor_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : xnor_operand_loader
//  Purpose  : Assembles an N-bit activation vector (op_x) and an N-bit weight
//             vector (op_w) from W-bit input beats and presents the complete
//             pair to the XNOR-popcount stage with a valid/ready handshake.
//             Single buffer: a new load starts only after the held pair has
//             been consumed.
//
//  Ports    : clk       in   1  rising-edge clock
//             rstn      in   1  asynchronous active-low reset
//             in_data   in   W  operand beat
//             in_valid  in   1  in_data valid
//             in_ready  out  1  loader accepts a beat (registered)
//             sync_clr  in   1  synchronous abort of the current load
//             keep_w    in   1  (XNOR_LOADER_WREUSE_EN only) reuse held weights
//             op_x      out  N  assembled activation vector
//             op_w      out  N  assembled weight vector
//             op_valid  out  1  op_x/op_w complete and stable
//             op_ready  in   1  downstream consumes the operand pair
//
//  Options  : define XNOR_LOADER_WREUSE_EN to add keep_w. When keep_w is high
//             on the final X beat, the W load is skipped and the previous
//             weights are presented again with the new activations.
//
//  Revision : 1.0  initial release
// ============================================================================
module xnor_operand_loader #(
   parameter int N = 1200,
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         sync_clr,
`ifdef XNOR_LOADER_WREUSE_EN
   input  logic         keep_w,
`endif
   output logic [N-1:0] op_x,
   output logic [N-1:0] op_w,
   output logic         op_valid,
   input  logic         op_ready
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_CHUNKS = (N + W - 1) / W;
   localparam int c_CNT_W  = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;

   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CHUNKS - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_LOAD_X = 2'd0,
      ST_LOAD_W = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_in_ready;
   logic                 r_op_valid;

   logic                 w_accept;
   logic                 w_last_beat;
   logic                 w_wr_x;
   logic                 w_wr_w;
   logic                 w_keep_w;

`ifdef XNOR_LOADER_WREUSE_EN
   assign w_keep_w = keep_w;
`else
   assign w_keep_w = 1'b0;
`endif

   // A beat is only taken when the registered ready is high. sync_clr wins
   // over a coincident beat, so it also suppresses the data write.
   assign w_accept    = in_valid & r_in_ready & ~sync_clr;
   assign w_last_beat = (r_cnt == c_CNT_LAST);
   assign w_wr_x      = w_accept & (r_state == ST_LOAD_X);
   assign w_wr_w      = w_accept & (r_state == ST_LOAD_W);

   // ------------------------------------------------------------------------
   // Sequencer: LOAD_X -> LOAD_W -> HOLD -> LOAD_X
   // in_ready and op_valid are registered alongside the state so they change
   // in the cycle after the event that causes the transition.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_LOAD_X;
         r_cnt      <= '0;
         r_in_ready <= 1'b0;
         r_op_valid <= 1'b0;
      end else if (sync_clr) begin
         r_state    <= ST_LOAD_X;
         r_cnt      <= '0;
         r_in_ready <= 1'b1;
         r_op_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD_X: begin
               // Also covers the first cycle after reset release, where
               // ready is still low and comes up on this edge.
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  if (w_last_beat) begin
                     r_cnt <= '0;
                     if (w_keep_w) begin
                        r_state    <= ST_HOLD;
                        r_in_ready <= 1'b0;
                        r_op_valid <= 1'b1;
                     end else begin
                        r_state <= ST_LOAD_W;
                     end
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end

            ST_LOAD_W: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  if (w_last_beat) begin
                     r_cnt      <= '0;
                     r_state    <= ST_HOLD;
                     r_in_ready <= 1'b0;
                     r_op_valid <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end

            ST_HOLD: begin
               if (r_op_valid && op_ready) begin
                  r_state    <= ST_LOAD_X;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_op_valid <= 1'b0;
               end
            end

            default: begin
               // Unreachable encoding: restart a clean load.
               r_state    <= ST_LOAD_X;
               r_cnt      <= '0;
               r_in_ready <= 1'b1;
               r_op_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign op_valid = r_op_valid;

   // ------------------------------------------------------------------------
   // Operand storage, one register slice per beat position. The last slice
   // is narrower when N is not a multiple of W; the surplus high bits of
   // that beat are simply not stored. Slices not written in the current
   // load keep their old contents.
   // ------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < c_CHUNKS; g++) begin : g_chunk
         localparam int c_LO  = g * W;
         localparam int c_WID = ((N - c_LO) < W) ? (N - c_LO) : W;
         localparam logic [c_CNT_W-1:0] c_IDX = c_CNT_W'(g);

         logic [c_WID-1:0] r_x;
         logic [c_WID-1:0] r_w;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_x <= '0;
               r_w <= '0;
            end else begin
               if (w_wr_x && (r_cnt == c_IDX)) begin
                  r_x <= in_data[c_WID-1:0];
               end
               if (w_wr_w && (r_cnt == c_IDX)) begin
                  r_w <= in_data[c_WID-1:0];
               end
            end
         end

         assign op_x[c_LO +: c_WID] = r_x;
         assign op_w[c_LO +: c_WID] = r_w;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_xnor_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xnor_operand_loader
//  Purpose  : Self-checking bench for xnor_operand_loader (N=1200, W=64).
//             A behavioural model tracks accepted beats as a plain count of
//             0..2*CHUNKS-1 and writes beat k into the expected vectors by
//             bit arithmetic. Table-driven loads, hand sequences for clear,
//             reset and (optionally, XNOR_LOADER_WREUSE_EN) weight reuse,
//             then a randomized run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xnor_operand_loader;

   localparam int N = 1200;
   localparam int W = 64;
   localparam int C = (N + W - 1) / W;

   logic         clk = 1'b0;
   logic         rstn;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         sync_clr;
   logic [N-1:0] op_x;
   logic [N-1:0] op_w;
   logic         op_valid;
   logic         op_ready;
`ifdef XNOR_LOADER_WREUSE_EN
   logic         keep_w = 1'b0;
`endif

   always #5 clk = ~clk;

   xnor_operand_loader #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sync_clr (sync_clr),
`ifdef XNOR_LOADER_WREUSE_EN
      .keep_w   (keep_w),
`endif
      .op_x     (op_x),
      .op_w     (op_w),
      .op_valid (op_valid),
      .op_ready (op_ready)
   );

   int total = 0;
   int bad   = 0;

   // Reference model
   int           m_n;
   bit           m_hold;
   bit           m_rdy;
   logic [N-1:0] m_x;
   logic [N-1:0] m_w;

   typedef struct {
      logic [W-1:0] xb;
      logic [W-1:0] wb;
      int           gap;
      int           hold;
      logic [47:0]  x_top;
      logic [47:0]  w_top;
   } vec_t;

   vec_t tbl [4];

   task automatic chk_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      logic [N-1:0] ta;
      logic [N-1:0] te;
      int first;
      total++;
      if (act !== exp) begin
         bad++;
         first = -1;
         for (int j = 0; j < C; j++) begin
            ta = act >> (j * W);
            te = exp >> (j * W);
            if (first < 0 && ta[W-1:0] !== te[W-1:0]) first = j;
         end
         ta = act >> (first * W);
         te = exp >> (first * W);
         $display("FAIL %s: chunk %0d got %h expected %h at %0t",
                  name, first, ta[W-1:0], te[W-1:0], $time);
      end
   endtask

   task automatic model_reset();
      m_n    = 0;
      m_hold = 1'b0;
      m_rdy  = 1'b0;
      m_x    = '0;
      m_w    = '0;
   endtask

   // Advance one clock: update the model from the inputs present at the
   // edge, then compare the DUT 1 time unit after the edge.
   task automatic cycle();
      bit acc;
      int k;
      if (rstn) begin
         acc = in_valid && m_rdy && !sync_clr;
         if (sync_clr) begin
            m_n    = 0;
            m_hold = 1'b0;
         end else if (m_hold) begin
            if (op_ready) begin
               m_hold = 1'b0;
               m_n    = 0;
            end
         end else if (acc) begin
            k = m_n;
            for (int b = 0; b < W; b++) begin
               if (k < C) begin
                  if (k * W + b < N) m_x[k * W + b] = in_data[b];
               end else begin
                  if ((k - C) * W + b < N) m_w[(k - C) * W + b] = in_data[b];
               end
            end
            m_n++;
            if (m_n == 2 * C) begin
               m_hold = 1'b1;
               m_n    = 0;
            end
`ifdef XNOR_LOADER_WREUSE_EN
            if (k == C - 1 && keep_w) begin
               m_hold = 1'b1;
               m_n    = 0;
            end
`endif
         end
         m_rdy = !m_hold;
      end
      @(posedge clk);
      #1;
      chk_bit("in_ready", in_ready, m_rdy);
      chk_bit("op_valid", op_valid, m_hold);
      if (m_hold) begin
         chk_vec("op_x", op_x, m_x);
         chk_vec("op_w", op_w, m_w);
      end
   endtask

   task automatic load_random_pair();
      for (int k = 0; k < 2 * C; k++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         cycle();
      end
      in_valid = 1'b0;
   endtask

   task automatic handshake();
      op_ready = 1'b1;
      in_valid = 1'b0;
      cycle();
      op_ready = 1'b0;
   endtask

   task automatic reset_now(input string tag);
      rstn = 1'b0;
      #1;
      model_reset();
      chk_bit({tag, " in_ready"}, in_ready, 1'b0);
      chk_bit({tag, " op_valid"}, op_valid, 1'b0);
      chk_vec({tag, " op_x"}, op_x, '0);
      chk_vec({tag, " op_w"}, op_w, '0);
   endtask

   initial begin
      #1_000_000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] sx;
      logic [N-1:0] sw;

      tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0,
                 48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA};
      tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 0, 10,
                 48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA};
      tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 1, 0,
                 48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA};
      tbl[3] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 3,
                 48'h4567_89AB_CDEF, 48'hBA98_7654_3210};

      in_valid = 1'b0;
      in_data  = '0;
      sync_clr = 1'b0;
      op_ready = 1'b0;

      // Reset state, checked before any clock edge
      reset_now("reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cycle();  // ready rises on the first edge after release

      // Table-driven operand loads
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 2 * C; k++) begin
            if (tbl[i].gap != 0) begin
               in_valid = 1'b0;
               in_data  = {$urandom, $urandom};
               cycle();
            end
            in_valid = 1'b1;
            in_data  = (k < C) ? tbl[i].xb : tbl[i].wb;
            cycle();
         end
         in_valid = 1'b0;
         chk_bit("tbl op_valid", op_valid, 1'b1);
         chk_bit("tbl in_ready", in_ready, 1'b0);
         chk_val("tbl x_top", {16'h0, op_x[N-1 -: 48]}, {16'h0, tbl[i].x_top});
         chk_val("tbl w_top", {16'h0, op_w[N-1 -: 48]}, {16'h0, tbl[i].w_top});
         chk_val("tbl x_low", op_x[W-1:0], tbl[i].xb);
         chk_val("tbl w_low", op_w[W-1:0], tbl[i].wb);
         if (tbl[i].xb == '1) chk_vec("tbl x_ones", op_x, '1);

         sx = op_x;
         sw = op_w;
         op_ready = 1'b0;
         in_valid = 1'b1;
         for (int h = 0; h < tbl[i].hold; h++) begin
            in_data = {$urandom, $urandom};
            cycle();
         end
         chk_vec("hold op_x", op_x, sx);
         chk_vec("hold op_w", op_w, sw);

         handshake();
         chk_bit("handoff in_ready", in_ready, 1'b1);
         chk_bit("handoff op_valid", op_valid, 1'b0);
      end

      // sync_clr with a coincident beat after 7 X beats
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         cycle();
      end
      sync_clr = 1'b1;
      in_valid = 1'b1;
      in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      cycle();
      sync_clr = 1'b0;
      chk_bit("clr in_ready", in_ready, 1'b1);
      chk_bit("clr op_valid", op_valid, 1'b0);
      load_random_pair();
      chk_bit("clr reload op_valid", op_valid, 1'b1);
      handshake();

      // Reset pulsed in the middle of the W load
      for (int k = 0; k < C + 5; k++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         cycle();
      end
      in_valid = 1'b0;
      #3;
      reset_now("midload reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cycle();
      load_random_pair();
      chk_bit("post reset op_valid", op_valid, 1'b1);
      handshake();

`ifdef XNOR_LOADER_WREUSE_EN
      // Weight reuse: keep_w on the last X beat skips the W load
      load_random_pair();
      sw = op_w;
      handshake();
      for (int k = 0; k < C; k++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         keep_w   = (k == C - 1);
         cycle();
      end
      in_valid = 1'b0;
      keep_w   = 1'b0;
      chk_bit("reuse op_valid", op_valid, 1'b1);
      chk_vec("reuse op_w", op_w, sw);
      handshake();
`endif

      // Randomized traffic against the model
      for (int r = 0; r < 3000; r++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = {$urandom, $urandom};
         op_ready = ($urandom_range(0, 2) == 0);
         sync_clr = ($urandom_range(0, 60) == 0);
`ifdef XNOR_LOADER_WREUSE_EN
         keep_w   = ($urandom_range(0, 1) == 0);
`endif
         cycle();
      end
      sync_clr = 1'b0;
      in_valid = 1'b0;
      op_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xnor_operand_loader.md
XNOR_OPERAND_LOADER -- requirements
Module: xnor_operand_loader

Interface
REQ-001 SHALL have parameter N, default 1200: operand vector width in bits.
REQ-002 SHALL have parameter W, default 64: input beat width; CHUNKS = ceil(N/W) (19 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_data  input  W  operand beat.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a beat (registered).
REQ-008 SHALL have port sync_clr  input  1  synchronous abort of the current load.
REQ-009 SHALL have port op_x  output  N  assembled activation vector, to the XNOR-popcount stage.
REQ-010 SHALL have port op_w  output  N  assembled weight vector, to the XNOR-popcount stage.
REQ-011 SHALL have port op_valid  output  1  op_x/op_w complete and stable.
REQ-012 SHALL have port op_ready  input  1  downstream consumes the operand pair.

Function
REQ-013 SHALL transfer a beat on a rising edge where in_valid=1 and in_ready=1; no other beat counts.
REQ-014 SHALL implement FSM states LOAD_X, LOAD_W, HOLD plus a beat counter 0..CHUNKS-1.
REQ-015 SHALL write beat k in LOAD_X to op_x[k*W +: W], and in LOAD_W to op_w[k*W +: W], clipped at bit N-1; excess bits of the last beat are discarded.
REQ-016 SHALL move LOAD_X->LOAD_W on the CHUNKS-th X beat and LOAD_W->HOLD on the CHUNKS-th W beat, resetting the counter on each transition.
REQ-017 SHALL assert op_valid and deassert in_ready in the cycle after the final W beat (latency 1 cycle).
REQ-018 SHALL hold in_ready=1 in LOAD_X/LOAD_W and 0 in HOLD.
REQ-019 SHALL keep op_valid, op_x and op_w stable in HOLD until op_valid&&op_ready, then go to LOAD_X with in_ready=1 and op_valid=0 on the next cycle.
REQ-020 SHALL leave op_x/op_w bits not yet written in the current load at their previous values; contents are don't-care while op_valid=0.
REQ-021 SHALL give sync_clr priority over all other events: state->LOAD_X, counter->0, op_valid->0, in_ready->1; any beat in the same cycle is discarded; op_x/op_w retained.
REQ-022 SHALL NOT overlap loading and holding (single buffer); no beat is accepted while op_valid=1.

Reset
REQ-023 SHALL, while rstn=0, force state LOAD_X, counter 0, op_x=0, op_w=0, op_valid=0, in_ready=0 immediately, independent of clk.
REQ-024 SHALL raise in_ready on the first rising edge after rstn deasserts; reset during any state, including mid-load, discards partial data.

Configuration
REQ-025 SHALL, when XNOR_LOADER_WREUSE_EN is defined, add input keep_w (1 bit), sampled on the final X beat; keep_w=1 moves LOAD_X->HOLD directly, leaving op_w unchanged; keep_w=0 behaves as REQ-016.
REQ-026 SHALL, when XNOR_LOADER_WREUSE_EN is undefined, omit keep_w and always load W.

Verification (N=1200, W=64)
REQ-027 SHALL cover: reset, 19 all-ones X beats then 19 beats of 64'hAAAA_AAAA_AAAA_AAAA, op_ready=1 -> op_valid=1 one cycle after beat 38, op_x all ones, op_w alternating 1010 with bits 1199..1152 = 48'hAAAA_AAAA_AAAA, in_ready=1 the cycle after the handshake.
REQ-028 SHALL cover: op_ready=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0, op_valid=1, op_x/op_w unchanged throughout.
REQ-029 SHALL cover: in_valid toggled every other cycle -> only accepted beats counted, final vectors identical to REQ-027.
REQ-030 SHALL cover: sync_clr with a valid beat after 7 X beats -> that beat discarded, counter 0; next 38 beats yield a correct operand pair.
REQ-031 SHALL cover: rstn pulsed low mid-W load -> op_x=0, op_w=0, op_valid=0, in_ready=0 before the next edge.
REQ-032 SHALL cover, with XNOR_LOADER_WREUSE_EN: keep_w=1 on the 19th X beat -> op_valid after 19 beats, op_w equal to the previous pair's weights.
